// File: rtl/ctrl_plane_sender.sv
// Host-side control-plane load transmitter: start_loader pulse, fixed gap, then ST/CFG/INB words at one per clock.
// Optional lane-XOR checksum of all sent words is built only when CTRL_PLANE_SENDER_CHECKSUM_EN is defined.
module ctrl_plane_sender #(
  parameter int phit_size    = 512,
  parameter int dwidth_RFadd = 5,
  parameter int NUM_PE       = 6,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [dwidth_RFadd-1:0] num_entry_config_table,
  input  logic [dwidth_RFadd-1:0] num_entry_inbound,
  input  logic [phit_size-1:0]    src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic                    start_loader,
  output logic [phit_size-1:0]    wr_data_ctrl_plane,
  output logic                    start_stream_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err_underflow,
  output logic [63:0]             checksum
);
  localparam int CW = dwidth_RFadd + 3;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_XFER, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {PH_ST, PH_CFG, PH_INB} phase_t;

  state_t                  state_q, state_d;
  phase_t                  phase_q, phase_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [dwidth_RFadd-1:0] ncfg_q, ncfg_d, ninb_q, ninb_d;
  logic                    start_loader_q, start_loader_d;
  logic [phit_size-1:0]    wr_data_q, wr_data_d;
  logic                    sss_q, sss_d;
  logic                    fin_q, fin_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept_go;
  logic [CW-1:0]           len [3];
  logic                    nxt_vld;
  phase_t                  nxt_ph;
  logic [CW-1:0]           nxt_cnt;

  assign accept_go = go && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  // First non-empty sub-phase after the current one (or from ST when not yet transferring).
  always_comb begin
    int first_ph;
    len[0]   = {3'b000, ncfg_q};
    len[1]   = {3'b000, ncfg_q} * CW'(NUM_PE);
    len[2]   = {3'b000, ninb_q};
    first_ph = (state_q == S_XFER) ? int'(phase_q) + 1 : 0;
    nxt_vld  = 1'b0;
    nxt_ph   = PH_ST;
    nxt_cnt  = '0;
    for (int p = 2; p >= 0; p--) begin
      if (p >= first_ph && len[p] != '0) begin
        nxt_vld = 1'b1;
        nxt_ph  = phase_t'(2'(p));
        nxt_cnt = len[p];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    ncfg_d         = ncfg_q;
    ninb_d         = ninb_q;
    start_loader_d = 1'b0;
    wr_data_d      = '0;
    err_d          = err_q;
    fin_d          = 1'b0;
    src_ready      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          ncfg_d  = num_entry_config_table;
          ninb_d  = num_entry_inbound;
          err_d   = 1'b0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        start_loader_d = 1'b1;
        gap_d          = '0;
        state_d        = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (nxt_vld) begin
            state_d = S_XFER;
            phase_d = nxt_ph;
            cnt_d   = nxt_cnt;
          end else begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end
        end
      end
      S_XFER: begin
        src_ready = 1'b1;
        if (src_valid) begin
          wr_data_d = src_data;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            if (nxt_vld) begin
              phase_d = nxt_ph;
              cnt_d   = nxt_cnt;
            end else begin
              state_d = S_DONE;
              fin_d   = 1'b1;
            end
          end
        end else begin
          // Loader cannot stall, so a missing word is fatal for this load.
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = fin_q;
    sss_d  = !(state_q == S_DONE && !go);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phase_q        <= PH_ST;
      cnt_q          <= '0;
      gap_q          <= '0;
      ncfg_q         <= '0;
      ninb_q         <= '0;
      start_loader_q <= 1'b0;
      wr_data_q      <= '0;
      sss_q          <= 1'b1;
      fin_q          <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      ncfg_q         <= ncfg_d;
      ninb_q         <= ninb_d;
      start_loader_q <= start_loader_d;
      wr_data_q      <= wr_data_d;
      sss_q          <= sss_d;
      fin_q          <= fin_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign start_loader       = start_loader_q;
  assign wr_data_ctrl_plane = wr_data_q;
  assign start_stream_in    = sss_q;
  assign done               = done_q;
  assign err_underflow      = err_q;
  assign busy               = (state_q == S_PULSE) || (state_q == S_GAP) || (state_q == S_XFER);

`ifdef CTRL_PLANE_SENDER_CHECKSUM_EN
  logic [63:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (accept_go) begin
      cks_d = '0;
    end else if (state_q == S_XFER && src_valid) begin
      for (int j = 0; j < phit_size / 64; j++) begin
        cks_d = cks_d ^ src_data[64*j +: 64];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ctrl_plane_sender.sv
// Scoreboard bench for ctrl_plane_sender: expected words, start_loader and done cycles are queued at stimulus time
// and popped by a negedge monitor; end-of-load state is checked against hand-derived values.
module tb_ctrl_plane_sender;
  localparam int PW = 512;
  localparam int DW = 5;
`ifdef CTRL_PLANE_SENDER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [DW-1:0] ncfg, ninb;
  logic [PW-1:0] src_data;
  logic          src_valid;
  logic          src_ready, start_loader, start_stream_in, busy, done, err_underflow;
  logic [PW-1:0] wr_data;
  logic [63:0]   checksum;

  ctrl_plane_sender dut (
    .clk                    (clk),
    .rst                    (rst),
    .go                     (go),
    .num_entry_config_table (ncfg),
    .num_entry_inbound      (ninb),
    .src_data               (src_data),
    .src_valid              (src_valid),
    .src_ready              (src_ready),
    .start_loader           (start_loader),
    .wr_data_ctrl_plane     (wr_data),
    .start_stream_in        (start_stream_in),
    .busy                   (busy),
    .done                   (done),
    .err_underflow          (err_underflow),
    .checksum               (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            t;
    logic [PW-1:0] w;
  } exp_word_t;

  exp_word_t     q_word[$];
  int            q_sl[$];
  int            q_done[$];
  logic [PW-1:0] src_mem [64];
  int            src_len  = 0;
  int            src_idx  = 0;
  int            drop_idx = -1;
  bit            acc_prev = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] fold(input logic [PW-1:0] w);
    logic [63:0] f;
    f = '0;
    for (int j = 0; j < PW / 64; j++) f = f ^ w[64*j +: 64];
    return f;
  endfunction

  // Monitor first (uses last cycle's handshake), then advance and drive the source.
  always @(negedge clk) begin
    if (rst) begin
      acc_prev  = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
    end else begin
      if (acc_prev) begin
        if (q_word.size() == 0) begin
          chk("extra_word", wr_data, '0);
        end else begin
          exp_word_t e;
          e = q_word.pop_front();
          chk("word_cycle", PW'(cyc), PW'(e.t));
          chk("word_data", wr_data, e.w);
        end
      end else begin
        chk("wr_idle_zero", wr_data, '0);
      end
      if (start_loader) begin
        if (q_sl.size() == 0) chk("extra_start_loader", 1'b1, 1'b0);
        else                  chk("start_loader_cycle", PW'(cyc), PW'(q_sl.pop_front()));
      end
      if (done) begin
        if (q_done.size() == 0) chk("extra_done", 1'b1, 1'b0);
        else                    chk("done_cycle", PW'(cyc), PW'(q_done.pop_front()));
      end
      if (acc_prev) src_idx++;
      src_valid = (src_idx < src_len) && (src_idx != drop_idx);
      src_data  = src_valid ? src_mem[src_idx] : '0;
      acc_prev  = src_ready && src_valid;
    end
  end

  // Queue expectations and pulse go; returns T0 and the model checksum of the words that will be sent.
  task automatic prep_load(input int cfg, input int inb, input int drop, output int t0, output logic [63:0] cks,
                           output bit exp_err);
    int n, nsent;
    n       = cfg + 6 * cfg + inb;
    nsent   = (drop >= 0 && drop < n) ? drop : n;
    exp_err = (nsent < n);
    @(posedge clk); #1;
    ncfg     = DW'(cfg);
    ninb     = DW'(inb);
    src_len  = n;
    drop_idx = drop;
    src_idx  = 0;
    t0       = cyc + 1;
    cks      = '0;
    q_sl.push_back(t0 + 1);
    for (int i = 0; i < nsent; i++) begin
      q_word.push_back('{t0 + 4 + i, src_mem[i]});
      cks = cks ^ fold(src_mem[i]);
    end
    if (!exp_err) q_done.push_back(t0 + 4 + n);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("t0_busy", busy, 1'b1);
    chk("t0_err_cleared", err_underflow, 1'b0);
    chk("t0_stream_hold", start_stream_in, 1'b1);
    chk("t0_checksum_cleared", checksum, '0);
  endtask

  task automatic run_load(input int cfg, input int inb, input int drop, input bit go_mid,
                          input bit use_fixed, input logic [63:0] fixed_cks);
    int          t0, k;
    logic [63:0] cks, exp_cks;
    bit          exp_err;
    prep_load(cfg, inb, drop, t0, cks, exp_err);
    k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1;
      go = (go_mid && k == 6);
      k++;
    end
    go = 1'b0;
    chk("load_timeout", busy, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    exp_cks = CKS_EN ? (use_fixed ? fixed_cks : cks) : 64'h0;
    chk("end_err_underflow", err_underflow, exp_err);
    chk("end_stream_in", start_stream_in, exp_err);
    chk("end_wr_zero", wr_data, '0);
    chk("end_checksum", checksum, exp_cks);
    chk("words_missing", PW'(q_word.size()), '0);
    chk("done_missing", PW'(q_done.size()), '0);
    chk("start_loader_missing", PW'(q_sl.size()), '0);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < PW / 64; j++)
        src_mem[i][64*j +: 64] = {32'(i + 1), 32'(j) * 32'h1111 + 32'hA5};
  endtask

  task automatic fill_const_tail(input int nzero, input int nconst);
    for (int i = 0; i < 64; i++) src_mem[i] = '0;
    for (int i = nzero; i < nzero + nconst; i++) src_mem[i] = {8{64'h3ff0000000000000}};
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_start_loader"}, start_loader, 1'b0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_src_ready"}, src_ready, 1'b0);
    chk({tag, "_stream_in"}, start_stream_in, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err_underflow, 1'b0);
    chk({tag, "_checksum"}, checksum, '0);
  endtask

  initial begin
    int          t0;
    logic [63:0] cks;
    bit          exp_err;
    rst = 1'b1; go = 1'b0; ncfg = '0; ninb = '0; src_data = '0; src_valid = 1'b0;
    #1;
    chk_reset_values("rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Baseline 2/16 load: 30 words in order, done at T34.
    fill_pattern();
    run_load(2, 16, -1, 1'b0, 1'b0, 64'h0);
    // Checksum folding cases.
    fill_const_tail(14, 16);
    run_load(2, 16, -1, 1'b0, 1'b1, 64'h0);
    fill_const_tail(14, 1);
    run_load(2, 1, -1, 1'b0, 1'b1, 64'h0);
    fill_const_tail(14, 16);
    src_mem[3][63:0] = 64'h1;
    run_load(2, 16, -1, 1'b0, 1'b1, 64'h1);
    // Underflow at the 5th transfer cycle, then recovery with an inbound-only load.
    fill_pattern();
    run_load(2, 16, 4, 1'b0, 1'b0, 64'h0);
    run_load(0, 3, -1, 1'b0, 1'b0, 64'h0);
    // Nothing to send.
    run_load(0, 0, -1, 1'b0, 1'b0, 64'h0);
    // go pulsed mid-transfer must be ignored.
    run_load(2, 16, -1, 1'b1, 1'b0, 64'h0);

    // Asynchronous reset at T10 of a load.
    prep_load(2, 16, -1, t0, cks, exp_err);
    while (cyc < t0 + 10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("midload_rst");
    q_word.delete();
    q_done.delete();
    q_sl.delete();
    @(posedge clk); #1 rst = 1'b0;
    run_load(2, 16, -1, 1'b0, 1'b0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
